// File: rtl/multibank_fifo_ctrl.sv
// Ring controller for NUM_BANKS external FIFO banks used as a multi-buffer.
// Optional MBFC_FLUSH_EN adds a flush input that seals a partially filled write bank.
module multibank_fifo_ctrl #(
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned RESET_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_BANKS-1:0]             full,
  input  logic [NUM_BANKS-1:0]             empty,
  input  logic                             wr_req,
  input  logic                             rd_req,
  input  logic                             err_clr,
`ifdef MBFC_FLUSH_EN
  input  logic                             flush,
`endif
  output logic [NUM_BANKS-1:0]             fifo_reset,
  output logic [NUM_BANKS-1:0]             wr_en,
  output logic [NUM_BANKS-1:0]             rd_en,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic                             error,
  output logic [$clog2(NUM_BANKS+1)-1:0]   sealed_cnt
);

  localparam int unsigned PW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned CW = $clog2(NUM_BANKS + 1);
  localparam int unsigned RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {
    RST_SEQ,
    RUN,
    ERR
  } state_t;

  state_t               state, state_nxt;
  logic [RW-1:0]        rst_cnt;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [NUM_BANKS-1:0] sealed, sealed_nxt;
  logic [CW-1:0]        cnt_nxt;
  logic                 seal, drain, err_det, rst_done, flush_hit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_BANKS - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef MBFC_FLUSH_EN
  assign flush_hit = flush && !empty[wr_ptr];
`else
  assign flush_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RST_SEQ;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_reset = '0;
    wr_en      = '0;
    rd_en      = '0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    seal       = 1'b0;
    drain      = 1'b0;
    err_det    = 1'b0;
    rst_done   = (rst_cnt == RW'(RESET_CYCLES - 1));
    case (state)
      RST_SEQ: begin
        fifo_reset = '1;
        if (rst_done) state_nxt = RUN;
      end
      RUN: begin
        in_ready  = !sealed[wr_ptr] && !full[wr_ptr];
        out_valid = sealed[rd_ptr] && !empty[rd_ptr];
        if (wr_req && in_ready)  wr_en[wr_ptr] = 1'b1;
        if (rd_req && out_valid) rd_en[rd_ptr] = 1'b1;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
          if (full[i] && empty[i])                             err_det = 1'b1;
          if (!sealed[i] && (PW'(i) != wr_ptr) && !empty[i])   err_det = 1'b1;
          if (sealed[i] && empty[i] && full[i])                err_det = 1'b1;
        end
        // A flush coinciding with full on the same bank still yields one seal.
        seal  = !sealed[wr_ptr] && (full[wr_ptr] || flush_hit);
        drain = sealed[rd_ptr] && empty[rd_ptr];
        if (err_det) begin
          state_nxt = ERR;
          seal      = 1'b0;
          drain     = 1'b0;
        end
      end
      ERR: begin
        fifo_reset = '1;
        state_nxt  = RST_SEQ;
      end
      default: state_nxt = RST_SEQ;
    endcase

    sealed_nxt = sealed;
    if (seal)  sealed_nxt[wr_ptr] = 1'b1;
    if (drain) sealed_nxt[rd_ptr] = 1'b0;
    if ((state == RST_SEQ) && rst_done) sealed_nxt = '0;

    // sealed_cnt tracks the registered sealed vector, so count its next value.
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++)
      cnt_nxt = cnt_nxt + CW'(sealed_nxt[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sealed     <= '0;
      sealed_cnt <= '0;
      error      <= 1'b0;
    end else begin
      sealed     <= sealed_nxt;
      sealed_cnt <= cnt_nxt;
      rst_cnt    <= ((state == RST_SEQ) && !rst_done) ? rst_cnt + RW'(1) : '0;
      if ((state == RST_SEQ) && rst_done) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (seal)  wr_ptr <= ptr_inc(wr_ptr);
        if (drain) rd_ptr <= ptr_inc(rd_ptr);
      end
      if (err_det)      error <= 1'b1;
      else if (err_clr) error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multibank_fifo_ctrl.sv
// Directed bench for multibank_fifo_ctrl: a 2-bank instance and a 4-bank instance.
// Bank flags are driven directly; MBFC_FLUSH_EN enables the flush scenario.
module tb_multibank_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 2-bank instance
  logic       a_rst_n, a_wr_req, a_rd_req, a_err_clr, a_flush;
  logic [1:0] a_full, a_empty, a_fifo_reset, a_wr_en, a_rd_en, a_sealed_cnt;
  logic       a_in_ready, a_out_valid, a_error;

  // 4-bank instance
  logic       b_rst_n, b_wr_req, b_rd_req, b_err_clr, b_flush;
  logic [3:0] b_full, b_empty, b_fifo_reset, b_wr_en, b_rd_en;
  logic [2:0] b_sealed_cnt;
  logic       b_in_ready, b_out_valid, b_error;

  multibank_fifo_ctrl #(.NUM_BANKS(2), .RESET_CYCLES(4)) u_dut_a (
    .clk(clk), .reset_n(a_rst_n), .full(a_full), .empty(a_empty),
    .wr_req(a_wr_req), .rd_req(a_rd_req), .err_clr(a_err_clr),
`ifdef MBFC_FLUSH_EN
    .flush(a_flush),
`endif
    .fifo_reset(a_fifo_reset), .wr_en(a_wr_en), .rd_en(a_rd_en),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .error(a_error),
    .sealed_cnt(a_sealed_cnt)
  );

  multibank_fifo_ctrl #(.NUM_BANKS(4), .RESET_CYCLES(4)) u_dut_b (
    .clk(clk), .reset_n(b_rst_n), .full(b_full), .empty(b_empty),
    .wr_req(b_wr_req), .rd_req(b_rd_req), .err_clr(b_err_clr),
`ifdef MBFC_FLUSH_EN
    .flush(b_flush),
`endif
    .fifo_reset(b_fifo_reset), .wr_en(b_wr_en), .rd_en(b_rd_en),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .error(b_error),
    .sealed_cnt(b_sealed_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst_n = 1'b0; a_wr_req = 1'b0; a_rd_req = 1'b0; a_err_clr = 1'b0; a_flush = 1'b0;
    a_full = 2'b00; a_empty = 2'b11;
    b_rst_n = 1'b0; b_wr_req = 1'b0; b_rd_req = 1'b0; b_err_clr = 1'b0; b_flush = 1'b0;
    b_full = 4'b0000; b_empty = 4'b1111;
    #1;
    a_wr_req = 1'b1;
    #1;
    check("a_rst_fifo_reset", a_fifo_reset, 2'b11);
    check("a_rst_wr_en", a_wr_en, 2'b00);
    check("a_rst_in_ready", a_in_ready, 0);
    check("a_rst_out_valid", a_out_valid, 0);
    check("a_rst_sealed_cnt", a_sealed_cnt, 0);
    check("a_rst_error", a_error, 0);
    a_wr_req = 1'b0;
    tick(); tick();

    // reset sequence: fifo_reset held for exactly 4 cycles
    a_rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("a_seq_fifo_reset", a_fifo_reset, 2'b11);
      tick();
    end
    check("a_run_fifo_reset", a_fifo_reset, 2'b00);
    check("a_run_in_ready", a_in_ready, 1);
    check("a_run_out_valid", a_out_valid, 0);

    // fill and seal bank0
    a_wr_req = 1'b1; a_empty = 2'b10;
    #1 check("a_fill0_wr_en", a_wr_en, 2'b01);
    a_full = 2'b01;
    #1 check("a_full0_in_ready", a_in_ready, 0);
    check("a_full0_wr_en", a_wr_en, 2'b00);
    tick();
    check("a_seal0_cnt", a_sealed_cnt, 1);
    check("a_seal0_wr_en", a_wr_en, 2'b10);
    a_rd_req = 1'b1;
    #1 check("a_rd0_out_valid", a_out_valid, 1);
    check("a_rd0_rd_en", a_rd_en, 2'b01);
    a_full = 2'b00;
    tick();
    check("a_rd0b_rd_en", a_rd_en, 2'b01);
    a_wr_req = 1'b0; a_empty = 2'b11;
    #1 check("a_empty0_rd_en", a_rd_en, 2'b00);
    tick();
    check("a_drain0_cnt", a_sealed_cnt, 0);
    check("a_drain0_out_valid", a_out_valid, 0);

    // seal bank1 and read it: proves rd_ptr moved to 1, wr_ptr wraps to 0
    a_full = 2'b10; a_empty = 2'b01;
    tick();
    check("a_seal1_cnt", a_sealed_cnt, 1);
    check("a_rd1_rd_en", a_rd_en, 2'b10);
    a_full = 2'b00; a_empty = 2'b11;
    tick();
    check("a_drain1_cnt", a_sealed_cnt, 0);
    a_rd_req = 1'b0;

    // error: full and empty on bank1
    a_full = 2'b10; a_empty = 2'b11;
    tick();
    check("a_err_flag", a_error, 1);
    check("a_err_fifo_reset", a_fifo_reset, 2'b11);
    check("a_err_in_ready", a_in_ready, 0);
    a_full = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("a_err_seq_fifo_reset", a_fifo_reset, 2'b11);
    end
    tick();
    check("a_err_run_fifo_reset", a_fifo_reset, 2'b00);
    check("a_err_sticky", a_error, 1);
    check("a_err_run_in_ready", a_in_ready, 1);
    a_wr_req = 1'b1;
    #1 check("a_err_ptr0_wr_en", a_wr_en, 2'b01);
    a_wr_req = 1'b0;
    a_err_clr = 1'b1;
    tick();
    a_err_clr = 1'b0;
    check("a_err_cleared", a_error, 0);

    // new error in the same cycle as err_clr: error wins
    a_full = 2'b01; a_empty = 2'b01; a_err_clr = 1'b1;
    tick();
    check("a_err_wins", a_error, 1);
    a_err_clr = 1'b0; a_full = 2'b00; a_empty = 2'b11;
    repeat (5) tick();
    check("a_err2_run_fifo_reset", a_fifo_reset, 2'b00);
    a_err_clr = 1'b1;
    tick();
    a_err_clr = 1'b0;
    check("a_err2_cleared", a_error, 0);

    // asynchronous reset in the middle of a drain
    a_full = 2'b01; a_empty = 2'b10;
    tick();
    a_full = 2'b00; a_rd_req = 1'b1;
    #1 check("a_mid_rd_en", a_rd_en, 2'b01);
    #2 a_rst_n = 1'b0;
    #1;
    check("a_async_fifo_reset", a_fifo_reset, 2'b11);
    check("a_async_rd_en", a_rd_en, 2'b00);
    check("a_async_out_valid", a_out_valid, 0);
    check("a_async_sealed_cnt", a_sealed_cnt, 0);
    check("a_async_in_ready", a_in_ready, 0);
    a_empty = 2'b11; a_rd_req = 1'b0;
    tick();
    a_rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("a_reseq_fifo_reset", a_fifo_reset, 2'b11);
      tick();
    end
    check("a_reseq_run_fifo_reset", a_fifo_reset, 2'b00);

`ifdef MBFC_FLUSH_EN
    // flush a partially filled bank0 holding 3 words
    a_wr_req = 1'b1; a_empty = 2'b10;
    #1 check("a_fl_wr_en", a_wr_en, 2'b01);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("a_fl_cnt", a_sealed_cnt, 1);
    check("a_fl_wr_en_moved", a_wr_en, 2'b10);
    check("a_fl_out_valid", a_out_valid, 1);
    a_rd_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check("a_fl_rd_en", a_rd_en, 2'b01);
      tick();
    end
    a_empty = 2'b11;
    #1 check("a_fl_empty_out_valid", a_out_valid, 0);
    tick();
    check("a_fl_drain_cnt", a_sealed_cnt, 0);
    a_wr_req = 1'b0; a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("a_fl_empty_ignored", a_sealed_cnt, 0);
    a_full = 2'b10; a_empty = 2'b01;
    tick();
    check("a_fl_rdptr1_rd_en", a_rd_en, 2'b10);
    a_rd_req = 1'b0;
`endif

    // 4-bank ring: fill all banks without reading
    b_rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("b_seq_fifo_reset", b_fifo_reset, 4'b1111);
      tick();
    end
    check("b_run_fifo_reset", b_fifo_reset, 4'b0000);
    b_wr_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_empty[k] = 1'b0;
      #1 check("b_fill_wr_en", b_wr_en, 32'd1 << k);
      b_full[k] = 1'b1;
      #1 check("b_full_in_ready", b_in_ready, 0);
      tick();
    end
    check("b_all_cnt", b_sealed_cnt, 4);
    check("b_all_in_ready", b_in_ready, 0);
    check("b_all_wr_en", b_wr_en, 4'b0000);
    check("b_all_out_valid", b_out_valid, 1);
    check("b_stall_no_error", b_error, 0);
    b_rd_req = 1'b1;
    #1 check("b_rd0_rd_en", b_rd_en, 4'b0001);
    b_full[0] = 1'b0; b_empty[0] = 1'b1;
    #1 check("b_empty0_rd_en", b_rd_en, 4'b0000);
    tick();
    check("b_drain0_cnt", b_sealed_cnt, 3);
    check("b_wrap_in_ready", b_in_ready, 1);
    check("b_wrap_wr_en", b_wr_en, 4'b0001);
    check("b_rd1_rd_en", b_rd_en, 4'b0010);

    // seal bank0 and drain bank1 in the same cycle
    b_empty[0] = 1'b0; b_full[0] = 1'b1; b_full[1] = 1'b0; b_empty[1] = 1'b1;
    tick();
    check("b_both_cnt", b_sealed_cnt, 3);
    check("b_both_rd_en", b_rd_en, 4'b0100);
    check("b_both_wr_en", b_wr_en, 4'b0010);

    // unsealed non-write bank reporting data is an error
    b_full[2] = 1'b0; b_empty[2] = 1'b1; b_rd_req = 1'b0;
    tick();
    check("b_drain2_cnt", b_sealed_cnt, 2);
    b_empty[2] = 1'b0;
    #1 check("b_pre_err", b_error, 0);
    tick();
    check("b_err_flag", b_error, 1);
    check("b_err_fifo_reset", b_fifo_reset, 4'b1111);
    check("b_err_wr_en", b_wr_en, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
